// File: rtl/jpeg_vlc_pack_if.sv
// Signal bundle for jpeg_vlc_pack: token input, Huffman ROM port and packed byte output.
interface jpeg_vlc_pack_if;
    logic [3:0]  rlen;
    logic [3:0]  size;
    logic [11:0] amp;
    logic        douten;
    logic        bstart;
    logic        flush;
    logic [8:0]  tbl_addr;
    logic [15:0] tbl_code;
    logic [4:0]  tbl_len;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        flush_done;
    logic        ovf;

    modport master (
        output rlen, size, amp, douten, bstart, flush, tbl_code, tbl_len,
        input  tbl_addr, dout, dout_valid, flush_done, ovf
    );

    modport slave (
        input  rlen, size, amp, douten, bstart, flush, tbl_code, tbl_len,
        output tbl_addr, dout, dout_valid, flush_done, ovf
    );
endinterface

// File: rtl/jpeg_vlc_pack.sv
// JPEG entropy-coder back end: turns (rlen,size,amp) tokens into a byte-stuffed
// bitstream, looking codes up in an external registered Huffman ROM.
module jpeg_vlc_pack #(
    parameter int BUF_W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    jpeg_vlc_pack_if.slave bus
);

    logic [11:0]      pred, diff, mag;
    logic [3:0]       dc_size;
    logic             s1_valid, s2_valid;
    logic [3:0]       s1_size, s2_size;
    logic [11:0]      s1_amp, s2_amp;
    logic [8:0]       addr_r;
    logic             hold_valid;
    logic [15:0]      hold_code;
    logic [4:0]       hold_len;
    logic [BUF_W-1:0] acc, acc_next, ins_tok, ins_pad, bits;
    logic [7:0]       count, count_next;
    logic             stuff_pend, flush_pend, ovf_r;
    logic [7:0]       dout_r;
    logic             dout_valid_r, flush_done_r;
    logic [15:0]      code_sel, code_mask;
    logic [4:0]       len_sel;
    logic [11:0]      ampv, amp_mask;
    logic [7:0]       app_len, pad_len;
    logic             pipe_empty, tok_app, tok_drop, do_pad, emit_stuff, emit_byte, done;

    function automatic logic [3:0] bit_count(input logic [11:0] m);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 12; i++)
            if (m[i]) n = 4'(i + 1);
        return n;
    endfunction

    always_comb begin
        diff    = bus.amp - pred;
        mag     = diff[11] ? 12'(-diff) : diff;
        dc_size = bit_count(mag);
    end

    // ROM data matches stage 2 only right after an enabled edge, so a stall
    // parks that code in the hold registers until the pipeline moves again.
    always_comb begin
        code_sel   = hold_valid ? hold_code : bus.tbl_code;
        len_sel    = hold_valid ? hold_len : bus.tbl_len;
        code_mask  = 16'((17'd1 << len_sel) - 17'd1);
        amp_mask   = 12'((13'd1 << s2_size) - 13'd1);
        ampv       = s2_amp[11] ? s2_amp - 12'd1 : s2_amp;
        app_len    = 8'(len_sel) + 8'(s2_size);
        bits       = (BUF_W'(code_sel & code_mask) << s2_size) | BUF_W'(ampv & amp_mask);
        ins_tok    = (bits << (BUF_W - int'(app_len))) >> count;
        pad_len    = (count[2:0] == 3'd0) ? 8'd0 : 8'd8 - 8'(count[2:0]);
        ins_pad    = ({BUF_W{1'b1}} << (BUF_W - int'(pad_len))) >> count;
        pipe_empty = !s1_valid && !s2_valid && !bus.douten;
        tok_app    = s2_valid && ((count + app_len) <= 8'(BUF_W));
        tok_drop   = s2_valid && !tok_app;
        do_pad     = flush_pend && pipe_empty && (pad_len != 8'd0);
        emit_stuff = stuff_pend;
        emit_byte  = !stuff_pend && (count >= 8'd8);
        done       = flush_pend && pipe_empty && (count == 8'd0) && !stuff_pend;
        acc_next   = acc | (tok_app ? ins_tok : '0) | (do_pad ? ins_pad : '0);
        if (emit_byte)
            acc_next = acc_next << 8;
        count_next = count + (tok_app ? app_len : 8'd0) + (do_pad ? pad_len : 8'd0)
                     - (emit_byte ? 8'd8 : 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred         <= '0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s1_size      <= '0;
            s2_size      <= '0;
            s1_amp       <= '0;
            s2_amp       <= '0;
            addr_r       <= '0;
            hold_valid   <= 1'b0;
            hold_code    <= '0;
            hold_len     <= '0;
            acc          <= '0;
            count        <= '0;
            stuff_pend   <= 1'b0;
            flush_pend   <= 1'b0;
            ovf_r        <= 1'b0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            flush_done_r <= 1'b0;
        end else if (ena) begin
            s1_valid <= bus.douten;
            if (bus.douten) begin
                addr_r  <= bus.bstart ? {1'b1, 4'd0, dc_size} : {1'b0, bus.rlen, bus.size};
                s1_size <= bus.bstart ? dc_size : bus.size;
                s1_amp  <= bus.bstart ? diff : bus.amp;
            end
            s2_valid   <= s1_valid;
            s2_size    <= s1_size;
            s2_amp     <= s1_amp;
            hold_valid <= 1'b0;
            acc        <= acc_next;
            count      <= count_next;
            if (tok_drop)
                ovf_r <= 1'b1;
            if (emit_stuff) begin
                dout_r     <= 8'h00;
                stuff_pend <= 1'b0;
            end else if (emit_byte) begin
                dout_r     <= acc[BUF_W-1 -: 8];
                stuff_pend <= (acc[BUF_W-1 -: 8] == 8'hFF);
            end
            dout_valid_r <= emit_stuff || emit_byte;
            flush_done_r <= done;
            if (bus.flush)
                flush_pend <= 1'b1;
            else if (done)
                flush_pend <= 1'b0;
            if (bus.douten && bus.bstart)
                pred <= bus.amp;
            else if (done)
                pred <= '0;
        end else begin
            dout_valid_r <= 1'b0;
            flush_done_r <= 1'b0;
            if (!hold_valid) begin
                hold_valid <= 1'b1;
                hold_code  <= bus.tbl_code;
                hold_len   <= bus.tbl_len;
            end
        end
    end

    assign bus.tbl_addr   = addr_r;
    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.flush_done = flush_done_r;
    assign bus.ovf        = ovf_r;

endmodule

// File: tb/tb_jpeg_vlc_pack.sv
// Directed bench for jpeg_vlc_pack: a bit-queue reference model fills a byte
// scoreboard as tokens are driven, and a negedge monitor pops it on every dout_valid.
module tb_jpeg_vlc_pack;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   sbEn = 1'b1;

    logic [7:0] expq[$];
    logic [7:0] obsq[$];
    int         obsCyc[$];
    bit         bitq[$];
    int         mpred = 0;
    logic [7:0] sbExp;
    logic [20:0] romWord;
    logic [7:0] eBytes[4] = '{8'hCB, 8'h03, 8'hA4, 8'h2A};

    jpeg_vlc_pack_if bus();

    jpeg_vlc_pack #(.BUF_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Huffman ROM: standard luminance DC table; AC entries carry junk above the code length.
    function automatic logic [20:0] rom(input logic [8:0] a);
        logic [15:0] c;
        logic [4:0]  l;
        if (a[8]) begin
            case (a[3:0])
                4'd0:    begin c = 16'h0000; l = 5'd2; end
                4'd1:    begin c = 16'h0002; l = 5'd3; end
                4'd2:    begin c = 16'h0003; l = 5'd3; end
                4'd3:    begin c = 16'h0004; l = 5'd3; end
                4'd4:    begin c = 16'h0005; l = 5'd3; end
                4'd5:    begin c = 16'h0006; l = 5'd3; end
                4'd6:    begin c = 16'h000E; l = 5'd4; end
                4'd7:    begin c = 16'h001E; l = 5'd5; end
                4'd8:    begin c = 16'h003E; l = 5'd6; end
                4'd9:    begin c = 16'h007E; l = 5'd7; end
                4'd10:   begin c = 16'h00FE; l = 5'd8; end
                default: begin c = 16'h01FE; l = 5'd9; end
            endcase
        end else if (a[7:0] == 8'h00) begin
            c = 16'h000A; l = 5'd4;
        end else if (a[7:0] == 8'hF0) begin
            c = 16'h07F9; l = 5'd11;
        end else if (a[3:0] == 4'd11) begin
            c = 16'hA5C3; l = 5'd16;
        end else begin
            c = {8'hC3, a[7:0]}; l = 5'd8;
        end
        return {c, l};
    endfunction

    always @(posedge clk) begin
        romWord = rom(bus.tbl_addr);
        bus.tbl_code <= romWord[20:5];
        bus.tbl_len  <= romWord[4:0];
    end

    always @(negedge clk) begin
        if (sbEn && bus.dout_valid === 1'b1) begin
            obsq.push_back(bus.dout);
            obsCyc.push_back(cyc);
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $error("[TB] FAIL sb_extra observed=%0h expected=none", bus.dout);
            end else begin
                sbExp = expq.pop_front();
                assert (bus.dout === sbExp) else begin
                    errors++;
                    $error("[TB] FAIL sb_byte observed=%0h expected=%0h", bus.dout, sbExp);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obsAt(input int i);
        return (i < obsq.size()) ? 32'(obsq[i]) : 32'hDEAD;
    endfunction

    task automatic pushBits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
    endtask

    task automatic drainBytes();
        logic [7:0] b;
        while (bitq.size() >= 8) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
            expq.push_back(b);
            if (b == 8'hFF) expq.push_back(8'h00);
        end
    endtask

    task automatic modelReset();
        expq.delete();
        bitq.delete();
        mpred = 0;
    endtask

    task automatic applyStimulus(input bit dc, input logic [3:0] r, input logic [3:0] s, input int a);
        int          v;
        int          m;
        int          sz;
        logic [8:0]  addr;
        logic [20:0] re;
        if (dc) begin
            v = a - mpred;
            mpred = a;
            m = (v < 0) ? -v : v;
            sz = 0;
            while (m != 0) begin
                sz++;
                m = m >> 1;
            end
            addr = {1'b1, 4'd0, 4'(sz)};
        end else begin
            v = a;
            sz = int'(s);
            addr = {1'b0, r, s};
        end
        if (sbEn) begin
            re = rom(addr);
            pushBits(32'(re[20:5]), int'(re[4:0]));
            if (sz > 0) pushBits((v < 0) ? v - 1 : v, sz);
            drainBytes();
        end
        bus.douten = 1'b1;
        bus.bstart = dc;
        bus.rlen   = r;
        bus.size   = s;
        bus.amp    = 12'(a);
        @(posedge clk); #1;
        bus.douten = 1'b0;
        bus.bstart = 1'b0;
    endtask

    task automatic applyFlush();
        bus.flush = 1'b1;
        if (sbEn) begin
            while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
            drainBytes();
            mpred = 0;
        end
        @(posedge clk); #1;
        bus.flush = 1'b0;
    endtask

    task automatic waitFlushDone(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.flush_done === 1'b1);
        end
        checkOutput({tag, "_done"}, 32'(seen), 32'd1);
        checkOutput({tag, "_drained"}, 32'(expq.size()), 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit sawDone;
        rst = 1'b1;
        ena = 1'b1;
        bus.rlen = '0; bus.size = '0; bus.amp = '0;
        bus.douten = 1'b0; bus.bstart = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_dout", bus.dout, 0);
        checkOutput("rst_dout_valid", bus.dout_valid, 0);
        checkOutput("rst_flush_done", bus.flush_done, 0);
        checkOutput("rst_ovf", bus.ovf, 0);
        checkOutput("rst_tbl_addr", bus.tbl_addr, 0);
        rst = 1'b0;

        $display("[TB] empty flush");
        applyFlush();
        @(negedge clk); checkOutput("empty_fd_c1", bus.flush_done, 0);
        @(negedge clk); checkOutput("empty_fd_c2", bus.flush_done, 1);
        @(negedge clk); checkOutput("empty_fd_c3", bus.flush_done, 0);

        $display("[TB] sequence A");
        obsq.delete();
        applyStimulus(1'b1, 4'd0, 4'd0, 5);
        applyStimulus(1'b0, 4'd0, 4'd0, 0);
        applyFlush();
        waitFlushDone("A");
        checkOutput("A_byte0", obsAt(0), 32'h96);
        checkOutput("A_byte1", obsAt(1), 32'hBF);
        checkOutput("A_count", 32'(obsq.size()), 2);
        @(negedge clk); checkOutput("A_done_pulse", bus.flush_done, 0);

        $display("[TB] sequence B");
        obsq.delete();
        applyStimulus(1'b1, 4'd0, 4'd0, 5);
        checkOutput("B_addr_dc5", bus.tbl_addr, 9'h103);
        applyStimulus(1'b0, 4'd0, 4'd0, 0);
        applyStimulus(1'b1, 4'd0, 4'd0, 2);
        checkOutput("B_addr_dc2", bus.tbl_addr, 9'h102);
        applyStimulus(1'b0, 4'd0, 4'd0, 0);
        applyFlush();
        waitFlushDone("B");
        checkOutput("B_byte0", obsAt(0), 32'h96);
        checkOutput("B_byte1", obsAt(1), 32'h99);
        checkOutput("B_byte2", obsAt(2), 32'h5F);

        $display("[TB] sequence C");
        obsq.delete();
        obsCyc.delete();
        applyStimulus(1'b0, 4'd15, 4'd0, 0);
        applyFlush();
        waitFlushDone("C");
        checkOutput("C_byte0", obsAt(0), 32'hFF);
        checkOutput("C_byte1", obsAt(1), 32'h00);
        checkOutput("C_byte2", obsAt(2), 32'h3F);
        checkOutput("C_stuff_adjacent", (obsCyc.size() >= 2) ? 32'(obsCyc[1] - obsCyc[0]) : 32'hDEAD, 1);

        $display("[TB] sequence D");
        sbEn = 1'b0;
        checkOutput("D_ovf_before", bus.ovf, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'd0, 4'd11, 1023);
        repeat (4) @(negedge clk);
        checkOutput("D_ovf_set", bus.ovf, 1);
        repeat (20) @(negedge clk);
        checkOutput("D_ovf_sticky", bus.ovf, 1);
        doReset();
        @(negedge clk);
        checkOutput("D_ovf_cleared", bus.ovf, 0);
        sbEn = 1'b1;

        $display("[TB] sequence E");
        obsq.delete();
        applyStimulus(1'b1, 4'd0, 4'd0, -20);
        applyStimulus(1'b0, 4'd0, 4'd3, 5);
        applyStimulus(1'b0, 4'd2, 4'd1, -1);
        applyStimulus(1'b0, 4'd0, 4'd0, 0);
        applyFlush();
        waitFlushDone("E1");
        for (int i = 0; i < 4; i++) checkOutput($sformatf("E1_byte%0d", i), obsAt(i), 32'(eBytes[i]));
        obsq.delete();
        applyStimulus(1'b1, 4'd0, 4'd0, -20);
        applyStimulus(1'b0, 4'd0, 4'd3, 5);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("E_stall_dv%0d", i), bus.dout_valid, 0);
        end
        ena = 1'b1;
        applyStimulus(1'b0, 4'd2, 4'd1, -1);
        applyStimulus(1'b0, 4'd0, 4'd0, 0);
        applyFlush();
        waitFlushDone("E2");
        checkOutput("E2_count", 32'(obsq.size()), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("E2_byte%0d", i), obsAt(i), 32'(eBytes[i]));

        $display("[TB] sequence F");
        obsq.delete();
        applyStimulus(1'b1, 4'd0, 4'd0, 7);
        applyFlush();
        doReset();
        @(negedge clk);
        checkOutput("F_dout", bus.dout, 0);
        checkOutput("F_dout_valid", bus.dout_valid, 0);
        checkOutput("F_flush_done", bus.flush_done, 0);
        checkOutput("F_ovf", bus.ovf, 0);
        checkOutput("F_tbl_addr", bus.tbl_addr, 0);
        sawDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.flush_done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("F_no_done", 32'(sawDone), 0);
        applyStimulus(1'b1, 4'd0, 4'd0, 5);
        checkOutput("F_addr_pred0", bus.tbl_addr, 9'h103);
        applyStimulus(1'b0, 4'd0, 4'd0, 0);
        applyFlush();
        waitFlushDone("F");
        checkOutput("F_byte0", obsAt(0), 32'h96);
        checkOutput("F_byte1", obsAt(1), 32'hBF);
        checkOutput("F_count", 32'(obsq.size()), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
